sram_ctrl: RTL and testbench

//  Single-port controller that sits directly upstream of testram (async SRAM model) in the ssmvga framebuffer path.

---
 rtl/sram_ctrl_if.sv | 30 +++
 rtl/sram_ctrl.sv | 128 ++++++++++++
 tb/tb_sram_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if
//   Request/response channel between a client (through the external arbiter)
//   and sram_ctrl.
//   req_valid / req_ready : one-request-at-a-time handshake, accept on valid&&ready
//   req_we                : 1 = write, 0 = read (sampled at accept)
//   req_addr / req_wdata  : address and write data (sampled at accept)
//   rd_valid / rd_data    : one-cycle read-return strobe and the captured data
//   master modport: client side; slave modport: controller side.
interface sram_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rd_valid, rd_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl
//   Single-port async SRAM sequencer for the ssmvga framebuffer path.
//   Accepts one read or write at a time and drives ADDR/WE/OE/DATA with a
//   fixed setup / pulse / hold pattern; reads return on a one-cycle rd_valid.
// Ports
//   clk50mhz : system clock, rising edge
//   reset    : synchronous, active-high
//   bus      : sram_ctrl_if slave (req_valid/req_ready/req_we/req_addr/
//              req_wdata/rd_valid/rd_data)
//   WE       : SRAM write enable, active-low
//   OE       : SRAM output enable, active-high
//   ADDR     : SRAM address, changes only on accept
//   DATA     : SRAM data, driven only during WR_SETUP/WR_PULSE/WR_HOLD
module sram_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int WR_PULSE = 1,   // 1..15
    parameter int RD_WAIT  = 1    // 1..15
) (
    input  logic              clk50mhz,
    input  logic              reset,
    sram_ctrl_if.slave        bus,
    output logic              WE,
    output logic              OE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] DATA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_RD_SETUP,
        S_RD_WAIT,
        S_RD_CAPT
    } state_t;

    // Counter is loaded with N-1 on entry so the state lasts exactly N cycles.
    localparam logic [3:0] WR_LOAD = 4'(WR_PULSE - 1);
    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] wdata_q;
    logic              data_oe;

    // data_oe is only set on a write accept and OE only rises from RD_SETUP,
    // so the two can never be high together.
    assign DATA = data_oe ? wdata_q : 'z;

    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            wdata_q       <= '0;
            data_oe       <= 1'b0;
            WE            <= 1'b1;
            OE            <= 1'b0;
            ADDR          <= '0;
            bus.req_ready <= 1'b1;
            bus.rd_valid  <= 1'b0;
            bus.rd_data   <= '0;
        end else begin
            bus.rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        ADDR          <= bus.req_addr;
                        wdata_q       <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        if (bus.req_we) begin
                            data_oe <= 1'b1;
                            state   <= S_WR_SETUP;
                        end else begin
                            state   <= S_RD_SETUP;
                        end
                    end
                end
                S_WR_SETUP: begin
                    WE    <= 1'b0;
                    cnt   <= WR_LOAD;
                    state <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (cnt == '0) begin
                        WE    <= 1'b1;
                        state <= S_WR_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_WR_HOLD: begin
                    data_oe       <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                S_RD_SETUP: begin
                    OE    <= 1'b1;
                    cnt   <= RD_LOAD;
                    state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_RD_CAPT;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RD_CAPT: begin
                    bus.rd_data   <= DATA;
                    bus.rd_valid  <= 1'b1;
                    OE            <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                default: begin
                    data_oe       <= 1'b0;
                    WE            <= 1'b1;
                    OE            <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl
//   Bench for sram_ctrl. Two instances share clock and reset: u0 with
//   WR_PULSE=1/RD_WAIT=1 and u1 with WR_PULSE=4/RD_WAIT=3, each attached to
//   its own behavioural async RAM. A single request driver is steered to one
//   instance by 'sel'. Table rows are single transactions; reset, back-to-back
//   and bus-contention cases are hand-written sequences.
module tb_sram_ctrl;

    localparam int WRP1 = 4;
    localparam int RDW1 = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic sel   = 1'b0;

    always #5 clk = ~clk;

    logic        drv_valid = 1'b0;
    logic        drv_we    = 1'b0;
    logic [15:0] drv_addr  = '0;
    logic [15:0] drv_wdata = '0;

    sram_ctrl_if #(.ADDR_W(16), .DATA_W(16)) if0 ();
    sram_ctrl_if #(.ADDR_W(16), .DATA_W(16)) if1 ();

    assign if0.req_valid = drv_valid & ~sel;
    assign if0.req_we    = drv_we;
    assign if0.req_addr  = drv_addr;
    assign if0.req_wdata = drv_wdata;
    assign if1.req_valid = drv_valid & sel;
    assign if1.req_we    = drv_we;
    assign if1.req_addr  = drv_addr;
    assign if1.req_wdata = drv_wdata;

    logic        WE0, OE0, WE1, OE1;
    logic [15:0] ADDR0, ADDR1;
    wire  [15:0] DATA0, DATA1;

    sram_ctrl #(.ADDR_W(16), .DATA_W(16), .WR_PULSE(1), .RD_WAIT(1)) u0 (
        .clk50mhz(clk), .reset(reset), .bus(if0),
        .WE(WE0), .OE(OE0), .ADDR(ADDR0), .DATA(DATA0)
    );

    sram_ctrl #(.ADDR_W(16), .DATA_W(16), .WR_PULSE(WRP1), .RD_WAIT(RDW1)) u1 (
        .clk50mhz(clk), .reset(reset), .bus(if1),
        .WE(WE1), .OE(OE1), .ADDR(ADDR1), .DATA(DATA1)
    );

    // Behavioural async RAMs: write while WE low, drive DATA when OE=1 and WE=1.
    logic [15:0] mem0 [0:65535];
    logic [15:0] mem1 [0:65535];
    always @(posedge clk) if (!WE0) mem0[ADDR0] <= DATA0;
    always @(posedge clk) if (!WE1) mem1[ADDR1] <= DATA1;
    assign DATA0 = (OE0 && WE0) ? mem0[ADDR0] : 'z;
    assign DATA1 = (OE1 && WE1) ? mem1[ADDR1] : 'z;

    // Observation muxed onto the selected instance.
    wire        s_we    = sel ? WE1 : WE0;
    wire        s_oe    = sel ? OE1 : OE0;
    wire [15:0] s_addr  = sel ? ADDR1 : ADDR0;
    wire [15:0] s_data  = sel ? DATA1 : DATA0;
    wire        s_doe   = sel ? u1.data_oe : u0.data_oe;
    wire        s_ready = sel ? if1.req_ready : if0.req_ready;
    wire        s_vld   = sel ? if1.rd_valid : if0.rd_valid;
    wire [15:0] s_rdata = sel ? if1.rd_data : if0.rd_data;
    int wrp_s, rdw_s;
    assign wrp_s = sel ? WRP1 : 1;
    assign rdw_s = sel ? RDW1 : 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Background monitors: controller driving DATA while OE is high, and a
    // log of every u0 read return.
    int          contention = 0;
    int          rd_cnt     = 0;
    logic [15:0] rd_log [0:255];
    always @(negedge clk) begin
        if ((OE0 && u0.data_oe) || (OE1 && u1.data_oe)) contention <= contention + 1;
        if (!sel && if0.rd_valid) begin
            rd_log[rd_cnt[7:0]] <= if0.rd_data;
            rd_cnt              <= rd_cnt + 1;
        end
    end

    typedef struct {
        logic        sel;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;   // write data, or expected read data
        logic        junk;   // drive random requests while busy
    } vec_t;

    // One transaction; cycle n = n-th cycle after the accept cycle.
    task automatic run_txn(input vec_t v, input int idx);
        int cyc_rdy = 0, cyc_vld = 0, we_low = 0, doe_cnt = 0;
        int bad_addr = 0, bad_data = 0;
        logic [15:0] got = '0;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        sel = v.sel;
        #1;
        chk({tag, "_idle_ready"}, 32'(s_ready), 32'd1);
        drv_valid = 1'b1;
        drv_we    = v.we;
        drv_addr  = v.addr;
        drv_wdata = v.data;
        @(negedge clk);
        drv_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (!s_we) we_low++;
            if (s_doe) begin
                doe_cnt++;
                if (s_data !== v.data) bad_data++;
            end
            if (s_addr !== v.addr) bad_addr++;
            if (s_vld && cyc_vld == 0) begin
                cyc_vld = n;
                got     = s_rdata;
            end
            if (s_ready) begin
                cyc_rdy = n;
                break;
            end
            if (v.junk) begin
                drv_valid = 1'b1;
                drv_we    = 1'($urandom);
                drv_addr  = 16'($urandom);
                drv_wdata = 16'($urandom);
            end
            @(negedge clk);
        end
        drv_valid = 1'b0;
        chk({tag, "_addr_stable"}, 32'(bad_addr), 32'd0);
        if (v.we) begin
            chk({tag, "_ready_cycle"}, 32'(cyc_rdy), 32'(wrp_s + 3));
            chk({tag, "_we_low"}, 32'(we_low), 32'(wrp_s));
            chk({tag, "_drive_cycles"}, 32'(doe_cnt), 32'(wrp_s + 2));
            chk({tag, "_wdata_bus"}, 32'(bad_data), 32'd0);
            chk({tag, "_no_rdvalid"}, 32'(cyc_vld), 32'd0);
        end else begin
            chk({tag, "_ready_cycle"}, 32'(cyc_rdy), 32'(rdw_s + 3));
            chk({tag, "_rd_latency"}, 32'(cyc_vld), 32'(rdw_s + 3));
            chk({tag, "_rd_data"}, 32'(got), 32'(v.data));
            chk({tag, "_no_we"}, 32'(we_low), 32'd0);
            chk({tag, "_no_drive"}, 32'(doe_cnt), 32'd0);
            @(negedge clk);
            chk({tag, "_rdvalid_1cyc"}, 32'(s_vld), 32'd0);
            chk({tag, "_rd_data_hold"}, 32'(s_rdata), 32'(v.data));
            chk({tag, "_oe_idle"}, 32'(s_oe), 32'd0);
        end
    endtask

    initial begin
        vec_t vecs [11];
        int   base;
        int   w;
        int   b2b_timeout;

        vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0010, 16'hBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 16'h00FF, 16'hA5A5, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 16'h00FF, 16'hA5A5, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 16'hFFFF, 16'h5A5A, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 16'hFFFF, 16'h5A5A, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 16'hFFFF, 16'h1234, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 16'hFFFF, 16'h1234, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 16'h0000, 16'h00FF, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 16'h0000, 16'h00FF, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 16'h0010, 16'hBEEF, 1'b0};

        // Power-up reset values
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready0", 32'(if0.req_ready), 32'd1);
        chk("rst_ready1", 32'(if1.req_ready), 32'd1);
        chk("rst_rdvalid", 32'(if0.rd_valid), 32'd0);
        chk("rst_rddata", 32'(if0.rd_data), 32'd0);
        chk("rst_we", 32'(WE0), 32'd1);
        chk("rst_oe", 32'(OE0), 32'd0);
        chk("rst_addr", 32'(ADDR0), 32'd0);
        chk("rst_drive", 32'(u0.data_oe), 32'd0);

        for (int i = 0; i < 11; i++) run_txn(vecs[i], i);

        // Reset in the middle of a write
        @(negedge clk);
        sel = 1'b0;
        drv_valid = 1'b1; drv_we = 1'b1; drv_addr = 16'h0020; drv_wdata = 16'h1111;
        @(negedge clk);
        drv_valid = 1'b0;
        @(negedge clk);
        chk("mw_we_low", 32'(WE0), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("mw_rst_we", 32'(WE0), 32'd1);
        chk("mw_rst_drive", 32'(u0.data_oe), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mw_post_we", 32'(WE0), 32'd1);
        chk("mw_post_oe", 32'(OE0), 32'd0);
        chk("mw_post_drive", 32'(u0.data_oe), 32'd0);
        chk("mw_post_ready", 32'(if0.req_ready), 32'd1);

        // Reset in the middle of a read: no rd_valid, rd_data back to 0
        base = rd_cnt;
        drv_valid = 1'b1; drv_we = 1'b0; drv_addr = 16'h0010;
        @(negedge clk);
        drv_valid = 1'b0;
        @(negedge clk);
        chk("mr_oe_high", 32'(OE0), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_rst_oe", 32'(OE0), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("mr_no_rdvalid", 32'(rd_cnt - base), 32'd0);
        chk("mr_rddata_rst", 32'(if0.rd_data), 32'd0);

        // Back-to-back: writes 0..7 (data=addr+1), then reads 0..7, valid held high
        base = rd_cnt;
        b2b_timeout = 0;
        drv_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drv_we    = (i < 8);
            drv_addr  = 16'(i % 8);
            drv_wdata = 16'((i % 8) + 1);
            w = 0;
            while (!if0.req_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w >= 20) b2b_timeout++;
            @(negedge clk);
        end
        drv_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("b2b_timeout", 32'(b2b_timeout), 32'd0);
        chk("b2b_rd_count", 32'(rd_cnt - base), 32'd8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("b2b_rd%0d", k), 32'(rd_log[8'(base + k)]), 32'(k + 1));

        chk("no_contention", 32'(contention), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
